// File: rtl/bcd_pkg.sv
// Shared definitions for the frequency-meter gate controller.
//   state_e    : gate sequencer states (IDLE, CLEAR, GATE, LATCH)
//   DIGIT_W    : width of one BCD digit
//   all_nines  : true when the low n digits of a BCD word are all 9
package bcd_pkg;

   localparam int DIGIT_W    = 4;
   // Widest counter the all-nines helper can inspect.
   localparam int MAX_DIGITS = 16;
   localparam int MAX_BITS   = MAX_DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_GATE  = 2'd2,
      ST_LATCH = 2'd3
   } state_e;

   // The caller zero-extends its N*4-bit value to MAX_BITS and passes n = N.
   function automatic logic all_nines(input logic [MAX_BITS-1:0] v, input int n);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < n && v[i*DIGIT_W +: DIGIT_W] != 4'd9) r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_gate_ctrl_if.sv
// Bundle between the frequency-meter top level and the gate controller.
//   inputs to controller : start, cont, sig_in, cnt_val[N*4]
//   outputs              : cnt_en, cnt_clr, busy, valid, dato[N*4], ovf,
//                          sel[SEL_W], dig[4]
//   modports             : master (top level side), slave (controller side)
interface bcd_gate_ctrl_if
   import bcd_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = 2
);
   logic                   start;
   logic                   cont;
   logic                   sig_in;
   logic [N*DIGIT_W-1:0]   cnt_val;
   logic                   cnt_en;
   logic                   cnt_clr;
   logic                   busy;
   logic                   valid;
   logic [N*DIGIT_W-1:0]   dato;
   logic                   ovf;
   logic [SEL_W-1:0]       sel;
   logic [DIGIT_W-1:0]     dig;

   modport master (
      output start, cont, sig_in, cnt_val,
      input  cnt_en, cnt_clr, busy, valid, dato, ovf, sel, dig
   );

   modport slave (
      input  start, cont, sig_in, cnt_val,
      output cnt_en, cnt_clr, busy, valid, dato, ovf, sel, dig
   );
endinterface

// File: rtl/bcd_gate_ctrl_sync_edge.sv
// sync_edge: brings an asynchronous input into the clk domain with two
// flops, then flags each rising edge with a registered one-cycle pulse.
// A rising edge on sig_in shows up on ev three clk edges later.
//   clk, rst (async, active-high), sig_in (async) -> ev (1-cycle pulse)
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic ev
);
   // [0],[1]: synchronizer stages; [2]: previous synchronized value
   logic [2:0] sh_q, sh_d;
   logic       ev_q, ev_d;

   always_comb begin
      sh_d = {sh_q[1:0], sig_in};
      ev_d = sh_q[1] & ~sh_q[2];
   end

   // NOTE: clocked state uses <= so every flop samples pre-edge values;
   // blocking = here would turn the shift chain into a single wire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q <= '0;
         ev_q <= 1'b0;
      end else begin
         sh_q <= sh_d;
         ev_q <= ev_d;
      end
   end

   assign ev = ev_q;
endmodule

// File: rtl/bcd_gate_ctrl.sv
// bcd_gate_ctrl: measurement sequencer for the cascaded BCD counter.
// Clears the counter, opens a GATE_CYCLES-long window in which synchronized
// rising edges of sig_in enable the counter, latches the result, then stops
// or (cont=1) restarts. Also scans display digits at one per SCAN_DIV cycles.
//   clk, rst (async, active-high)
//   bus (slave): start, cont, sig_in, cnt_val in; cnt_en, cnt_clr, busy,
//                valid, dato, ovf, sel, dig out
// Optional feature macro BCD_GATE_OVF_EN: sticky counter-wrap detection
// reported on ovf; without it ovf is constant 0.
module bcd_gate_ctrl
   import bcd_pkg::*;
#(
   parameter int N           = 4,
   parameter int GATE_CYCLES = 1000,
   parameter int SCAN_DIV    = 50000,
   parameter int SEL_W       = 2
) (
   input logic             clk,
   input logic             rst,
   bcd_gate_ctrl_if.slave  bus
);
   localparam int TW = $clog2(GATE_CYCLES);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0]    GATE_LOAD = TW'(GATE_CYCLES - 1);
   localparam logic [PW-1:0]    SCAN_LAST = PW'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(N - 1);

   state_e               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [N*DIGIT_W-1:0] dato_q, dato_d;
   logic                 valid_q, valid_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 ev;

   sync_edge u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_in (bus.sig_in),
      .ev     (ev)
   );

   // NOTE: every signal gets a default before the case, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      dato_d  = dato_q;
      valid_d = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
         ST_CLEAR: begin
            state_d = ST_GATE;
            timer_d = GATE_LOAD;   // GATE_CYCLES-1 down to 0 inclusive
         end
         ST_GATE: begin
            if (timer_q == '0) state_d = ST_LATCH;
            else               timer_d = timer_q - TW'(1);
         end
         ST_LATCH: begin
            // An ev in the last gate cycle has already reached cnt_val here.
            dato_d  = bus.cnt_val;
            valid_d = 1'b1;
            state_d = bus.cont ? ST_CLEAR : ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Free-running display scan, independent of the measurement state.
   always_comb begin
      presc_d = presc_q + PW'(1);
      sel_d   = sel_q;
      if (presc_q == SCAN_LAST) begin
         presc_d = '0;
         sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         dato_q  <= '0;
         valid_q <= 1'b0;
         presc_q <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         dato_q  <= dato_d;
         valid_q <= valid_d;
         presc_q <= presc_d;
         sel_q   <= sel_d;
      end
   end

   // Combinational so the counter steps on the same edge that retires ev.
   assign bus.cnt_en  = ev & (state_q == ST_GATE);
   assign bus.cnt_clr = (state_q == ST_CLEAR);
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.valid   = valid_q;
   assign bus.dato    = dato_q;
   assign bus.sel     = sel_q;

   always_comb begin
      bus.dig = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_q == SEL_W'(i)) bus.dig = dato_q[i*DIGIT_W +: DIGIT_W];
      end
   end

`ifdef BCD_GATE_OVF_EN
   logic ovf_acc_q, ovf_acc_d;
   logic ovf_q, ovf_d;

   // The counter wraps all-9s -> 0 on its own; an enabled step at all-9s
   // is the only sign of that wrap, so remember it for the whole gate.
   always_comb begin
      ovf_acc_d = ovf_acc_q;
      ovf_d     = ovf_q;
      if (state_q == ST_CLEAR)
         ovf_acc_d = 1'b0;
      else if (bus.cnt_en && all_nines(MAX_BITS'(bus.cnt_val), N))
         ovf_acc_d = 1'b1;
      if (state_q == ST_LATCH) ovf_d = ovf_acc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_acc_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         ovf_acc_q <= ovf_acc_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_gate_ctrl.sv
// Self-checking bench for bcd_gate_ctrl. Two instances: a 4-digit one with
// a 20-cycle gate and 3-cycle scan, and a 2-digit one with a 220-cycle gate
// for counter wrap. The BCD counter itself is modelled here as the
// surrounding top level would provide it.
module tb_bcd_gate_ctrl;
   localparam int G    = 20;
   localparam int G2   = 220;
   localparam int SDIV = 3;
   localparam int HIST = 8192;
`ifdef BCD_GATE_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bcd_gate_ctrl_if #(.N(4), .SEL_W(2)) bus ();
   bcd_gate_ctrl_if #(.N(2), .SEL_W(1)) bus2 ();

   bcd_gate_ctrl #(.N(4), .GATE_CYCLES(G), .SCAN_DIV(SDIV), .SEL_W(2)) u_dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   bcd_gate_ctrl #(.N(2), .GATE_CYCLES(G2), .SCAN_DIV(1), .SEL_W(1)) u_dut2 (
      .clk (clk), .rst (rst), .bus (bus2)
   );

   // ---------------- BCD arithmetic helpers ----------------
   function automatic int from_bcd(input logic [15:0] v, input int nd);
      int r = 0;
      for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v, input int nd);
      logic [15:0] r = '0;
      int x = v;
      for (int i = 0; i < nd; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] v, input int nd);
      return to_bcd((from_bcd(v, nd) + 1) % (10 ** nd), nd);
   endfunction

   // ---------------- counter models (cleared by rst OR cnt_clr) -------
   logic [15:0] cnt_q, cnt2_q;
   logic        override_en;
   logic [15:0] override_val;

   always @(posedge clk or posedge rst) begin
      if (rst)              cnt_q <= '0;
      else if (bus.cnt_clr) cnt_q <= '0;
      else if (bus.cnt_en)  cnt_q <= bcd_inc(cnt_q, 4);
   end
   always @(posedge clk or posedge rst) begin
      if (rst)               cnt2_q <= '0;
      else if (bus2.cnt_clr) cnt2_q <= '0;
      else if (bus2.cnt_en)  cnt2_q <= bcd_inc(cnt2_q, 2);
   end
   assign bus.cnt_val  = override_en ? override_val : cnt_q;
   assign bus2.cnt_val = cnt2_q[7:0];

   // ---------------- scoreboard state ----------------
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          vq_cyc[$];
   logic [15:0] vq_dato[$];
   logic        vq_ovf[$];
   int          clr_cnt, clr_last, busy_cnt;
   bit          sig_hist [HIST];
   int          r0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_log();
      vq_cyc.delete();
      vq_dato.delete();
      vq_ovf.delete();
      clr_cnt  = 0;
      clr_last = -1;
      busy_cnt = 0;
   endtask

   // One cycle: sample outputs at the falling edge, then drive inputs.
   task automatic tick(input logic sig, input logic st, output int m);
      @(negedge clk);
      m = cyc;
      if (bus.valid) begin
         vq_cyc.push_back(cyc);
         vq_dato.push_back(bus.dato);
         vq_ovf.push_back(bus.ovf);
      end
      if (bus.cnt_clr) begin
         clr_cnt++;
         clr_last = cyc;
      end
      if (bus.busy) busy_cnt++;
      bus.sig_in = sig;
      bus.start  = st;
      if (cyc < HIST) sig_hist[cyc] = sig;
   endtask

   // Reference: a rise of sig_in driven in cycle p yields an event three
   // edges later; with start driven in cycle s the gate spans cycles
   // s+2 .. s+1+G, so rises in cycles s-1 .. s-2+G are counted.
   function automatic int exp_count(input int s);
      int c = 0;
      for (int p = s - 1; p <= s - 2 + G; p++)
         if (p >= 1 && p < HIST && sig_hist[p] && !sig_hist[p-1]) c++;
      return c;
   endfunction

   function automatic logic pulse_at(input int d, input int first, input int period, input int np);
      logic r = 1'b0;
      for (int k = 0; k < np; k++)
         if (d >= first + k * period && d < first + k * period + period / 2) r = 1'b1;
      return r;
   endfunction

   typedef struct {
      int          first;    // first rise, cycles relative to start
      int          period;
      int          npulse;
      logic [15:0] exp_dato;
   } vec_t;
   vec_t tbl [6];

   task automatic ovf_run(input int nr, input logic [7:0] exp_d, input logic exp_o, input string tag);
      int         got = 0;
      logic [7:0] gd  = '0;
      logic       go  = 1'b0;
      for (int i = 0; i < 8 + G2 + 12; i++) begin
         int d;
         d = i - 8;
         @(negedge clk);
         if (bus2.valid) begin
            got++;
            gd = bus2.dato;
            go = bus2.ovf;
         end
         bus2.sig_in = (d >= 0 && d <= 2 * (nr - 1) && (d % 2) == 0);
         bus2.start  = (i == 8);
      end
      bus2.sig_in = 1'b0;
      check({tag, "_nvalid"}, got, 1);
      check({tag, "_dato"}, gd, exp_d);
      check({tag, "_ovf"}, go, exp_o);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m, s;
      logic [15:0] md;
      int es;

      tbl[0] = '{first: -1, period: 4, npulse: 8,  exp_dato: 16'h0005};
      tbl[1] = '{first: 18, period: 4, npulse: 1,  exp_dato: 16'h0001};
      tbl[2] = '{first: 19, period: 4, npulse: 1,  exp_dato: 16'h0000};
      tbl[3] = '{first: -2, period: 4, npulse: 1,  exp_dato: 16'h0000};
      tbl[4] = '{first: 0,  period: 2, npulse: 12, exp_dato: 16'h0010};
      tbl[5] = '{first: -5, period: 3, npulse: 10, exp_dato: 16'h0006};

      bus.start = 1'b0;  bus.cont = 1'b0;  bus.sig_in = 1'b0;
      bus2.start = 1'b0; bus2.cont = 1'b0; bus2.sig_in = 1'b0;
      override_en = 1'b0; override_val = '0;
      clear_log();

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_dato", bus.dato, 0);
      check("rst_sel", bus.sel, 0);
      check("rst_dig", bus.dig, 0);
      check("rst_cnt_clr", bus.cnt_clr, 0);
      check("rst_cnt_en", bus.cnt_en, 0);
      check("rst_ovf", bus.ovf, 0);
      check("rst_busy2", bus2.busy, 0);
      rst = 1'b0;
      r0  = cyc;

      // ---- single-shot vectors ----
      for (int k = 0; k < 6; k++) begin
         clear_log();
         s = 0;
         for (int i = 0; i < 8 + G + 10; i++) begin
            tick(pulse_at(i - 8, tbl[k].first, tbl[k].period, tbl[k].npulse), (i == 8), m);
            if (i == 8) s = m;
         end
         check($sformatf("vec%0d_nvalid", k), vq_cyc.size(), 1);
         if (vq_cyc.size() > 0) begin
            check($sformatf("vec%0d_valid_cyc", k), vq_cyc[0], s + 3 + G);
            check($sformatf("vec%0d_dato", k), vq_dato[0], tbl[k].exp_dato);
            check($sformatf("vec%0d_ovf", k), vq_ovf[0], 0);
         end
         check($sformatf("vec%0d_clr_cycles", k), clr_cnt, 1);
         check($sformatf("vec%0d_clr_at", k), clr_last, s + 1);
         check($sformatf("vec%0d_busy_cycles", k), busy_cnt, G + 2);
         check($sformatf("vec%0d_idle_after", k), bus.busy, 0);
      end

      // ---- continuous mode, cont dropped mid-gate of the third gate ----
      clear_log();
      s = 0;
      bus.cont = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick(((i % 4) < 2), (i == 2), m);
         if (i == 2) s = m;
         if (vq_cyc.size() == 2 && m == vq_cyc[1] + 10) bus.cont = 1'b0;
         if (vq_cyc.size() >= 3 && m > vq_cyc[2] + 30) break;
      end
      bus.cont = 1'b0;
      check("cont_nvalid", vq_cyc.size(), 3);
      for (int k = 0; k < 3 && k < vq_cyc.size(); k++) begin
         check($sformatf("cont%0d_valid_cyc", k), vq_cyc[k], s + 3 + G + k * (G + 2));
         check($sformatf("cont%0d_dato", k), vq_dato[k], to_bcd(exp_count(s + k * (G + 2)), 4));
      end
      if (vq_cyc.size() > 0) check("cont_dato_five", vq_dato[0], 16'h0005);
      check("cont_idle_after", bus.busy, 0);

      // ---- randomized single shots against the reference ----
      for (int t = 0; t < 6; t++) begin
         clear_log();
         s = 0;
         for (int i = 0; i < 4 + G + 12; i++) begin
            tick(1'($urandom_range(0, 1)), (i == 4), m);
            if (i == 4) s = m;
         end
         check($sformatf("rnd%0d_nvalid", t), vq_cyc.size(), 1);
         if (vq_cyc.size() > 0) begin
            check($sformatf("rnd%0d_valid_cyc", t), vq_cyc[0], s + 3 + G);
            check($sformatf("rnd%0d_dato", t), vq_dato[0], to_bcd(exp_count(s), 4));
         end
      end
      bus.sig_in = 1'b0;

      // ---- counter wrap on the 2-digit instance ----
      ovf_run(101, 8'h01, OVF_EXP, "wrap");
      ovf_run(3, 8'h03, 1'b0, "nowrap");

      // ---- display scan with dato = 4321 ----
      clear_log();
      override_en  = 1'b1;
      override_val = 16'h4321;
      for (int i = 0; i < G + 14; i++) tick(1'b0, (i == 2), m);
      override_en = 1'b0;
      check("scan_nvalid", vq_cyc.size(), 1);
      check("scan_dato", bus.dato, 16'h4321);
      md = 16'h4321;
      for (int i = 0; i < 16; i++) begin
         tick(1'b0, 1'b0, m);
         es = ((m - r0) / SDIV) % 4;
         check($sformatf("scan%0d_sel", i), bus.sel, es);
         check($sformatf("scan%0d_dig", i), bus.dig, (md >> (4 * es)) & 16'hF);
      end

      // ---- asynchronous reset in the middle of a gate ----
      clear_log();
      for (int i = 0; i < 12; i++) tick(((i % 4) < 2), (i == 1), m);
      check("midrst_pre_busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_valid", bus.valid, 0);
      check("midrst_dato", bus.dato, 0);
      check("midrst_sel", bus.sel, 0);
      check("midrst_dig", bus.dig, 0);
      check("midrst_cnt_clr", bus.cnt_clr, 0);
      check("midrst_cnt_en", bus.cnt_en, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      r0  = cyc;
      clear_log();
      for (int i = 0; i < G + 10; i++) tick(1'b0, 1'b0, m);
      check("midrst_no_valid", vq_cyc.size(), 0);
      check("midrst_stays_idle", busy_cnt, 0);
      check("midrst_dato_after", bus.dato, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
